// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a length-prefixed byte stream into instruction memory as little-endian words,
// holding the CPU in reset until the load completes.
module inst_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERR} state_t;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  count, hdr, wl_nx;
    logic [1:0]        idx;
    logic [23:0]       word;
    logic [ADDR_W-1:0] addr;
    logic              acc, restart;
    always_comb begin
        in_ready = state == HDR_LO || state == HDR_HI || state == DATA;
        acc      = in_valid && in_ready;
        restart  = start && (state == DONE || state == ERR);
        hdr      = CNT_W'({in_data, count[7:0]});
        wl_nx    = words_loaded + CNT_W'(1);
        done     = state == DONE;
        err      = state == ERR;
        cpu_hold = state != DONE;
        state_nx = state;
        case (state)
            HDR_LO:  state_nx = acc ? HDR_HI : HDR_LO;
            HDR_HI:  state_nx = !acc ? HDR_HI : hdr == '0 ? DONE : hdr > CNT_W'(DEPTH) ? ERR : DATA;
            DATA:    state_nx = acc && idx == 2'd3 && wl_nx == count ? DONE : DATA;
            default: state_nx = restart ? HDR_LO : state;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HDR_LO;
        else     state <= state_nx;
    end
    // Bytes shift in from the top so the first three land in word[7:0..23:16] by byte 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            idx          <= '0;
            word         <= '0;
            addr         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                idx          <= '0;
                addr         <= '0;
                words_loaded <= '0;
            end
            if (acc && state == HDR_LO) count <= {count[CNT_W-1:8], in_data};
            if (acc && state == HDR_HI) begin
                count <= hdr;
                idx   <= '0;
                addr  <= '0;
            end
            if (acc && state == DATA) begin
                idx  <= idx + 2'd1;
                word <= {in_data, word[23:8]};
                if (idx == 2'd3) begin
                    wr_en        <= 1'b1;
                    wr_addr      <= addr;
                    wr_data      <= {in_data, word};
                    addr         <= addr + ADDR_W'(1);
                    words_loaded <= wl_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed checks of header handling, word assembly, write timing, error and reset paths.
module tb_inst_mem_loader;
    logic        clk = 0, rst = 0;
    logic [7:0]  in_data = 0;
    logic        in_valid = 0, in_ready, start = 0;
    logic        wr_en, cpu_hold, done, err;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] words_loaded;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          qa[$], qc[$];
    logic [31:0] qd[$];
    logic [31:0] w2 [3] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};

    inst_mem_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wr_en) begin
        qa.push_back(int'(wr_addr));
        qd.push_back(wr_data);
        qc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        while (rnd && $urandom_range(0, 1) == 1) begin
            in_valid = 0;
            in_data  = 8'($urandom);
            step(1);
        end
        in_data  = b;
        in_valid = 1;
        step(1);
        in_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], rnd);
    endtask

    task automatic pulse_start();
        start = 1;
        step(1);
        start = 0;
        qa.delete(); qd.delete(); qc.delete();
    endtask

    initial begin
        #2 rst = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_wr_addr_data", {wr_addr, wr_data}, 0);
        step(2);
        rst = 0;
        step(1);

        // single word
        send(8'h01, 0); send(8'h00, 0); send(8'hB7, 0); send(8'h10, 0); send(8'h00, 0);
        chk("t1_no_early_wr", wr_en, 0);
        send(8'h00, 0);
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_addr", wr_addr, 0);
        chk("t1_wr_data", wr_data, 32'h000010B7);
        chk("t1_done", done, 1);
        chk("t1_cpu_hold", cpu_hold, 0);
        chk("t1_words", words_loaded, 1);
        chk("t1_in_ready", in_ready, 0);
        step(1);
        chk("t1_wr_single", wr_en, 0);
        chk("t1_nwrites", qa.size(), 1);

        // three words back-to-back
        pulse_start();
        chk("t2_restart", {done, err, cpu_hold, in_ready}, 4'b0011);
        chk("t2_words0", words_loaded, 0);
        send(8'h03, 0); send(8'h00, 0);
        for (int k = 0; k < 3; k++) send_word(w2[k], 0);
        chk("t2_last_wr", {wr_en, 26'd0, wr_addr}, {1'b1, 26'd0, 6'd2});
        chk("t2_done", done, 1);
        step(1);
        chk("t2_nwrites", qa.size(), 3);
        for (int k = 0; k < 3 && k < qa.size(); k++) begin
            chk($sformatf("t2_addr%0d", k), qa[k], k);
            chk($sformatf("t2_data%0d", k), qd[k], w2[k]);
        end
        if (qc.size() == 3) begin
            chk("t2_gap01", qc[1] - qc[0], 4);
            chk("t2_gap12", qc[2] - qc[1], 4);
        end
        chk("t2_words", words_loaded, 3);

        // zero-length program
        pulse_start();
        send(8'h00, 0); send(8'h00, 0);
        chk("t3_done", {done, cpu_hold, in_ready, err}, 4'b1000);
        chk("t3_words", words_loaded, 0);
        step(3);
        chk("t3_nwrites", qa.size(), 0);

        // oversize header then recovery
        pulse_start();
        send(8'h41, 0); send(8'h00, 0);
        chk("t4_err", {err, cpu_hold, in_ready, done}, 4'b1100);
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        step(2);
        chk("t4_nwrites", qa.size(), 0);
        chk("t4_still_err", err, 1);
        pulse_start();
        chk("t4_cleared", {err, done, cpu_hold, in_ready}, 4'b0011);
        send(8'h01, 0); send(8'h00, 0); send_word(32'hCAFEF00D, 0);
        step(1);
        chk("t4_nwrites2", qa.size(), 1);
        if (qa.size() == 1) chk("t4_wr", qd[0], 32'hCAFEF00D);
        chk("t4_done", done, 1);

        // gapped valid
        pulse_start();
        send(8'h02, 1); send(8'h00, 1);
        send_word(w2[0], 1); send_word(w2[1], 1);
        step(1);
        chk("t5_nwrites", qa.size(), 2);
        for (int k = 0; k < 2 && k < qa.size(); k++) begin
            chk($sformatf("t5_addr%0d", k), qa[k], k);
            chk($sformatf("t5_data%0d", k), qd[k], w2[k]);
        end
        chk("t5_done", {done, words_loaded}, {1'b1, 16'd2});

        // reset mid-word
        pulse_start();
        send(8'h02, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
        #2 rst = 1;
        #1;
        chk("t6_rst_out", {wr_en, cpu_hold, in_ready, done, err}, 5'b01100);
        chk("t6_rst_words", words_loaded, 0);
        chk("t6_rst_wr", {wr_addr, wr_data}, 0);
        step(1);
        rst = 0;
        step(2);
        chk("t6_nwrites", qa.size(), 0);
        send(8'h01, 0); send(8'h00, 0); send_word(32'h12345678, 0);
        step(1);
        chk("t6_nwrites2", qa.size(), 1);
        if (qa.size() == 1) chk("t6_wr", {qa[0][5:0], qd[0]}, {6'd0, 32'h12345678});

        // full capacity
        pulse_start();
        send(8'h40, 0); send(8'h00, 0);
        for (int k = 0; k < 64; k++) send_word(32'hA5000000 | k * 32'h00010203, 0);
        step(1);
        chk("t7_nwrites", qa.size(), 64);
        for (int k = 0; k < 64 && k < qa.size(); k++) begin
            chk($sformatf("t7_addr%0d", k), qa[k], k);
            chk($sformatf("t7_data%0d", k), qd[k], 32'hA5000000 | k * 32'h00010203);
        end
        chk("t7_done", {done, words_loaded}, {1'b1, 16'd64});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
